pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline. It generates per-latch enable/flush for IF_ID, ID_EX, EX_MEM and MEM_WB, plus the PC enable.
- Stalls on outstanding instruction or data memory accesses, tracking hits that arrive in different cycles.
- Inserts load-use bubbles.
- Squashes wrong-path instructions on a MEM-stage redirect.
- Freezes the machine on halt.
- Keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 32, width of stall_cycles counter
HAZARD_EN, 1, 1 = load-use detection active; 0 = detection disabled (bubble never inserted)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
ex_mem_dREN  in  1  load in MEM stage
ex_mem_dWEN  in  1  store in MEM stage
id_ex_dREN  in  1  load in EX stage
id_ex_rt  in  5  destination reg of EX-stage load
if_id_rs  in  5  rs of ID-stage instruction
if_id_rt  in  5  rt of ID-stage instruction
redirect  in  1  MEM-stage branch taken / jump / jr (PC must load non-PC4 target)
mem_wb_halt  in  1  halt instruction in WB
imem_ren  out  1  instruction read request
dmem_req  out  1  data request enable (gates dREN/dWEN to cache)
pc_en  out  1  PC register update
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch load enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load NOP/zero instead of data (valid only with matching _en)
halted  out  1  registered halt indicator
stall_cycles  out  CNT_W  saturating stall counter

Behaviour:
- Clock/reset: one clock CLK. Reset nRST is synchronous and active-low.
- Reset (nRST=0 at an edge): state=RUN, ihit_seen=0, dhit_seen=0, halted=0, stall_cycles=0.
  - While nRST=0, all combinational outputs are forced to 0.
- States: RUN, HALT.
  - RUN->HALT when mem_wb_halt=1.
  - HALT is absorbing until reset.
- dmem_op = ex_mem_dREN | ex_mem_dWEN.
- Sticky hits, RUN only:
  - ihit_seen sets when ihit & ~advance.
  - dhit_seen sets when dhit & dmem_op & ~advance.
  - Both clear on an advance cycle.
- advance = RUN & ~mem_wb_halt & (ihit|ihit_seen) & (~dmem_op | dhit | dhit_seen).
- imem_ren = RUN & ~ihit_seen.
- dmem_req = RUN & dmem_op & ~dhit_seen.
  - Prevents re-issuing a completed access while waiting on the other port.
- Non-advance cycle: all _en and _flush = 0 (full freeze).
- Advance cycle, default: pc_en = if_id_en = id_ex_en = ex_mem_en = mem_wb_en = 1; flushes 0.
- load_use = HAZARD_EN & id_ex_dREN & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
- Advance & redirect: if_id_flush = id_ex_flush = ex_mem_flush = 1; pc_en = 1; mem_wb_en = 1.
  - Redirect has priority over load_use, because the hazard instruction is itself squashed.
- Advance & load_use & ~redirect: pc_en = 0, if_id_en = 0, id_ex_en = 1 with id_ex_flush = 1 (bubble); ex_mem_en = mem_wb_en = 1.
  - Exactly one bubble per hazard: on the next advance, id_ex_dREN has moved on.
- mem_wb_halt=1 in RUN: same-cycle freeze (all enables 0, advance 0); halted=1 from the following cycle.
  - In HALT: imem_ren = dmem_req = 0, all enables 0.
- stall_cycles increments by 1 each RUN cycle with (~advance | (advance & load_use & ~redirect)).
  - Not counted: HALT cycles, and the mem_wb_halt cycle itself.
  - Saturates at 2^CNT_W - 1; no wrap.
- Simultaneous ihit and dhit in the same cycle: advance immediately; sticky bits stay 0.
- dhit with dmem_op=0 is ignored.

Test Plan:
- ihit=1 every cycle, no mem ops -> every cycle all enables 1, flushes 0; stall_cycles stays 0.
- Store in MEM (ex_mem_dWEN=1): ihit at cycle 2, dhit at cycle 5 ->
  - imem_ren=0 for cycles 3-5.
  - advance only at cycle 5.
  - dmem_req=1 through cycle 5.
  - stall_cycles=3 after cycle 5 (cycles 2-4).
- Load id_ex_rt=5, if_id_rs=5, ihit=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle normal; stall_cycles=1.
  - Repeat with id_ex_rt=0 -> no bubble.
  - Repeat with HAZARD_EN=0 -> no bubble.
- redirect=1 together with the load_use condition on an advance cycle -> three flushes asserted, pc_en=1, no bubble, counter unchanged.
- mem_wb_halt=1 -> same cycle all enables 0; halted=1 next cycle; ihit/dhit/redirect pulses afterwards produce no enables.
  - nRST=0 for one edge -> halted=0, state=RUN.
- Force stall_cycles to near max (CNT_W=4, 20 stalled cycles) -> value holds at 15.
  - Mid-stall reset clears the counter and sticky bits.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline sequencer: latch enables/flushes, PC enable,
// memory request gating, halt freeze and a saturating stall counter.
module pipeline_ctrl #(
    parameter int unsigned CNT_W     = 32,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             ex_mem_dREN,
    input  logic             ex_mem_dWEN,
    input  logic             id_ex_dREN,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             redirect,
    input  logic             mem_wb_halt,
    output logic             imem_ren,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t           state, state_next;
    logic             ihit_seen, ihit_seen_next;
    logic             dhit_seen, dhit_seen_next;
    logic             halted_next;
    logic [CNT_W-1:0] stall_cycles_next;

    logic run, dmem_op, advance, load_use, bubble;

    // State, sticky hit flags, halt flag and counter
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state        <= RUN;
            ihit_seen    <= 1'b0;
            dhit_seen    <= 1'b0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_next;
            ihit_seen    <= ihit_seen_next;
            dhit_seen    <= dhit_seen_next;
            halted       <= halted_next;
            stall_cycles <= stall_cycles_next;
        end
    end

    // Next state and all combinational outputs; everything is 0 while in reset
    always_comb begin
        state_next        = state;
        ihit_seen_next    = ihit_seen;
        dhit_seen_next    = dhit_seen;
        halted_next       = halted;
        stall_cycles_next = stall_cycles;
        imem_ren          = 1'b0;
        dmem_req          = 1'b0;
        pc_en             = 1'b0;
        if_id_en          = 1'b0;
        id_ex_en          = 1'b0;
        ex_mem_en         = 1'b0;
        mem_wb_en         = 1'b0;
        if_id_flush       = 1'b0;
        id_ex_flush       = 1'b0;
        ex_mem_flush      = 1'b0;

        run      = nRST && (state == RUN);
        dmem_op  = ex_mem_dREN || ex_mem_dWEN;
        advance  = run && !mem_wb_halt && (ihit || ihit_seen)
                   && (!dmem_op || dhit || dhit_seen);
        load_use = HAZARD_EN && id_ex_dREN && (id_ex_rt != 5'd0)
                   && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
        bubble   = load_use && !redirect;

        imem_ren = run && !ihit_seen;
        dmem_req = run && dmem_op && !dhit_seen;

        if (advance) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            // Redirect wins: the hazard instruction is squashed anyway
            if (redirect) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        if (run) begin
            if (advance) begin
                ihit_seen_next = 1'b0;
                dhit_seen_next = 1'b0;
            end else begin
                ihit_seen_next = ihit_seen || ihit;
                dhit_seen_next = dhit_seen || (dhit && dmem_op);
            end
            if (mem_wb_halt) begin
                state_next  = HALT;
                halted_next = 1'b1;
            end else if ((!advance || bubble) && (stall_cycles != '1)) begin
                stall_cycles_next = stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
